lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 i_clk  input  1  sole clock; all state on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  core requests a data memory access this cycle; sampled only in IDLE.
REQ-005 i_w_en  input  1  1 = store, 0 = load; the decoder's memory write enable.
REQ-006 i_fmt  input  3  decoder memory format (funct3): 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 i_addr  input  32  byte address from ALU result.
REQ-008 i_wdata  input  32  store data (rs2), right-aligned.
REQ-009 o_busy  output  1  high in every non-IDLE state; core stalls.
REQ-010 o_done  output  1  one-cycle pulse when an access completes.
REQ-011 o_err  output  1  one-cycle pulse on misaligned address or illegal i_fmt; no bus access.
REQ-012 o_rdata  output  32  load result, extended per format; held until next load completes.
REQ-013 o_bus_valid  output  1  bus request valid.
REQ-014 i_bus_ready  input  1  bus accepts request when valid and ready are both high.
REQ-015 o_bus_addr  output  32  word address (i_addr with bits 1:0 cleared).
REQ-016 o_bus_we  output  1  bus write strobe.
REQ-017 o_bus_be  output  4  byte enables.
REQ-018 o_bus_wdata  output  32  store data replicated onto lanes.
REQ-019 i_bus_rvalid  input  1  read data valid; considered only in RESP.
REQ-020 i_bus_rdata  input  32  read data word.

Function
REQ-021 The FSM SHALL have states IDLE, REQ and RESP.
REQ-022 IDLE, i_req=1, legal and aligned: latch address, format, write enable and formatted data; enter REQ next cycle.
REQ-023 IDLE, i_req=1, illegal i_fmt (011, 110, 111, or any non-B/H/W format with i_w_en=1) or misaligned: pulse o_err next cycle; stay in IDLE.
REQ-024 Misalignment: H/HU with addr[0]=1; W with addr[1:0]!=00.
REQ-025 REQ: o_bus_valid=1 and bus fields stable until handshake.
REQ-026 REQ handshake on a store: return to IDLE and pulse o_done next cycle.
REQ-027 REQ handshake on a load: enter RESP.
REQ-028 RESP, i_bus_rvalid=1: capture and extend data, pulse o_done, return to IDLE, all on the same edge.
REQ-029 Minimum latency from i_req to o_done SHALL be 2 cycles for a store and 3 cycles for a load.
REQ-030 Byte enables: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111.
REQ-031 Store data: B byte replicated x4; H halfword replicated x2; W unchanged.
REQ-032 Load data: the selected lane SHALL be sign-extended for B/H and zero-extended for BU/HU; W unchanged.
REQ-033 i_req in a non-IDLE state SHALL be ignored; the core holds it while o_busy is high.
REQ-034 An i_bus_rvalid outside RESP SHALL be ignored.

Reset
REQ-035 Assertion SHALL immediately force IDLE, and all outputs (including o_rdata) to 0, regardless of the state in progress.
REQ-036 An access interrupted by reset SHALL be abandoned; late bus responses SHALL be ignored.

Configuration
REQ-037 With LSU_MISALIGN_CHECK_EN defined, misalignment SHALL raise o_err per REQ-023.
REQ-038 Without LSU_MISALIGN_CHECK_EN, misalignment SHALL NOT be checked: address low bits below the access size are treated as zero; illegal i_fmt still raises o_err.

Structure
REQ-039 A shared package SHALL hold the mem_fmt_t enum (B, H, W, BU, HU codes) and the lsu_state_t enum.
REQ-040 A combinational sub-module lsu_lane SHALL implement byte-enable generation, store replication and load extraction/extension.

Verification
REQ-041 SB, addr 0x103, wdata 0x000000A5, ready immediately -> be=1000, bus_addr 0x100, wdata 0xA5A5A5A5, o_done on cycle 2.
REQ-042 LH, addr 0x202, rdata 0x8001_1234 after 2 wait cycles -> o_rdata 0xFFFF8001; LHU -> 0x00008001.
REQ-043 LW, addr 0x006, with macro defined -> o_err pulse next cycle, o_bus_valid never high; without macro -> bus_addr 0x004, normal completion.
REQ-044 SW with i_bus_ready held low 5 cycles -> valid, address, be and data held constant; o_done 1 cycle after ready.
REQ-045 Reset asserted in RESP, then rvalid pulsed -> outputs 0 immediately, no o_done, state IDLE.
REQ-046 i_fmt=011 load -> o_err pulse; i_fmt=100 store -> o_err pulse.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: memory format codes,
// FSM state encoding and format legality/alignment helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    FMT_B  = 3'b000,
    FMT_H  = 3'b001,
    FMT_W  = 3'b010,
    FMT_BU = 3'b100,
    FMT_HU = 3'b101
  } mem_fmt_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_t;

  // Unsigned formats only make sense for loads.
  function automatic logic fmt_legal(input logic [2:0] fmt, input logic w_en);
    case (fmt)
      FMT_B, FMT_H, FMT_W: return 1'b1;
      FMT_BU, FMT_HU:      return !w_en;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic fmt_misaligned(input logic [2:0] fmt, input logic [1:0] off);
    case (fmt)
      FMT_H, FMT_HU: return off[0];
      FMT_W:         return |off;
      default:       return 1'b0;
    endcase
  endfunction

  // Clears the address bits below the access size.
  function automatic logic [1:0] align_offset(input logic [2:0] fmt, input logic [1:0] off);
    case (fmt)
      FMT_H, FMT_HU: return {off[1], 1'b0};
      FMT_W:         return 2'b00;
      default:       return off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic: byte enables, store data replication and load lane
// extraction with sign/zero extension.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Select the addressed byte and halfword of the read word.
  always_comb begin
    sel_byte = load_word[7:0];
    case (offset)
      2'd0: sel_byte = load_word[7:0];
      2'd1: sel_byte = load_word[15:8];
      2'd2: sel_byte = load_word[23:16];
      2'd3: sel_byte = load_word[31:24];
      default: sel_byte = load_word[7:0];
    endcase
    sel_half = offset[1] ? load_word[31:16] : load_word[15:0];
  end

  // Format-dependent enables, store replication and load extension.
  always_comb begin
    byte_en     = '0;
    store_lanes = store_data;
    load_data   = load_word;
    case (fmt)
      FMT_B: begin
        byte_en     = 4'b0001 << offset;
        store_lanes = {4{store_data[7:0]}};
        load_data   = {{24{sel_byte[7]}}, sel_byte};
      end
      FMT_BU: begin
        byte_en     = 4'b0001 << offset;
        store_lanes = {4{store_data[7:0]}};
        load_data   = {24'd0, sel_byte};
      end
      FMT_H: begin
        byte_en     = 4'b0011 << offset;
        store_lanes = {2{store_data[15:0]}};
        load_data   = {{16{sel_half[15]}}, sel_half};
      end
      FMT_HU: begin
        byte_en     = 4'b0011 << offset;
        store_lanes = {2{store_data[15:0]}};
        load_data   = {16'd0, sel_half};
      end
      FMT_W: begin
        byte_en     = 4'b1111;
        store_lanes = store_data;
        load_data   = load_word;
      end
      default: begin
        byte_en     = '0;
        store_lanes = store_data;
        load_data   = load_word;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE/REQ/RESP bus sequencer between the core and a
// valid/ready data bus with a separate read-response channel.
// Optional: define LSU_MISALIGN_CHECK_EN to reject misaligned accesses with
// o_err; otherwise low address bits below the access size are ignored.
module lsu
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_w_en,
  input  logic [2:0]  i_fmt,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_bus_valid,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  lsu_state_t  state;
  logic [2:0]  fmt_q;
  logic [1:0]  off_q;
  logic [1:0]  req_off;
  logic        req_bad;
  logic        misalign;
  logic [2:0]  lane_fmt;
  logic [1:0]  lane_off;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  // Request qualification in IDLE.
  always_comb begin
`ifdef LSU_MISALIGN_CHECK_EN
    misalign = fmt_misaligned(i_fmt, i_addr[1:0]);
`else
    misalign = 1'b0;
`endif
    req_bad = !fmt_legal(i_fmt, i_w_en) || misalign;
    req_off = align_offset(i_fmt, i_addr[1:0]);
  end

  // One lane instance serves both directions: the incoming request drives it
  // in IDLE (store lanes/enables), the latched access drives it afterwards
  // (load extraction in RESP).
  always_comb begin
    lane_fmt = (state == S_IDLE) ? i_fmt : fmt_q;
    lane_off = (state == S_IDLE) ? req_off : off_q;
  end

  lsu_lane u_lane (
    .fmt         (lane_fmt),
    .offset      (lane_off),
    .store_data  (i_wdata),
    .load_word   (i_bus_rdata),
    .byte_en     (lane_be),
    .store_lanes (lane_wdata),
    .load_data   (lane_rdata)
  );

  // Access sequencer with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      fmt_q       <= '0;
      off_q       <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_rdata     <= '0;
      o_bus_valid <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_we    <= 1'b0;
      o_bus_be    <= '0;
      o_bus_wdata <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req) begin
            if (req_bad) begin
              o_err <= 1'b1;
            end else begin
              state       <= S_REQ;
              o_busy      <= 1'b1;
              o_bus_valid <= 1'b1;
              o_bus_addr  <= {i_addr[31:2], 2'b00};
              o_bus_we    <= i_w_en;
              o_bus_be    <= lane_be;
              o_bus_wdata <= lane_wdata;
              fmt_q       <= i_fmt;
              off_q       <= req_off;
            end
          end
        end
        S_REQ: begin
          if (i_bus_ready) begin
            o_bus_valid <= 1'b0;
            if (o_bus_we) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (i_bus_rvalid) begin
            state   <= S_IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_rdata <= lane_rdata;
          end
        end
        default: begin
          state       <= S_IDLE;
          o_busy      <= 1'b0;
          o_bus_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu with hand-computed expected values.
module tb_lsu;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req;
  logic        i_w_en;
  logic [2:0]  i_fmt;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_rdata;
  logic        o_bus_valid;
  logic        i_bus_ready;
  logic [31:0] o_bus_addr;
  logic        o_bus_we;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;

  int checks = 0;
  int errors = 0;

  lsu dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req        (i_req),
    .i_w_en       (i_w_en),
    .i_fmt        (i_fmt),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_rdata      (o_rdata),
    .o_bus_valid  (o_bus_valid),
    .i_bus_ready  (i_bus_ready),
    .o_bus_addr   (o_bus_addr),
    .o_bus_we     (o_bus_we),
    .o_bus_be     (o_bus_be),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_rvalid (i_bus_rvalid),
    .i_bus_rdata  (i_bus_rdata)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present a request for one edge, then drop i_req.
  task automatic issue(input logic w_en, input logic [2:0] fmt,
                       input logic [31:0] addr, input logic [31:0] wdata);
    i_req   = 1'b1;
    i_w_en  = w_en;
    i_fmt   = fmt;
    i_addr  = addr;
    i_wdata = wdata;
    tick();
    i_req   = 1'b0;
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_req        = 1'b0;
    i_w_en       = 1'b0;
    i_fmt        = 3'b000;
    i_addr       = '0;
    i_wdata      = '0;
    i_bus_ready  = 1'b0;
    i_bus_rvalid = 1'b0;
    i_bus_rdata  = '0;
    tick();
    tick();
    check("rst_busy",  o_busy, 0);
    check("rst_done",  o_done, 0);
    check("rst_err",   o_err, 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_valid", o_bus_valid, 0);
    check("rst_addr",  o_bus_addr, 0);
    check("rst_be",    o_bus_be, 0);
    check("rst_wdata", o_bus_wdata, 0);
    i_rst_n = 1'b1;
    tick();

    // SB 0x103, bus ready immediately
    i_bus_ready = 1'b1;
    issue(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
    check("sb_busy",  o_busy, 1);
    check("sb_valid", o_bus_valid, 1);
    check("sb_addr",  o_bus_addr, 32'h0000_0100);
    check("sb_be",    o_bus_be, 4'b1000);
    check("sb_wdata", o_bus_wdata, 32'hA5A5_A5A5);
    check("sb_we",    o_bus_we, 1);
    check("sb_done0", o_done, 0);
    tick();
    check("sb_done",  o_done, 1);
    check("sb_idle",  o_busy, 0);
    check("sb_vdrop", o_bus_valid, 0);
    tick();
    check("sb_pulse", o_done, 0);

    // LH 0x202, response after 2 wait cycles
    issue(1'b0, 3'b001, 32'h0000_0202, '0);
    check("lh_valid", o_bus_valid, 1);
    check("lh_addr",  o_bus_addr, 32'h0000_0200);
    check("lh_be",    o_bus_be, 4'b1100);
    check("lh_we",    o_bus_we, 0);
    tick();
    check("lh_resp_busy",  o_busy, 1);
    check("lh_resp_valid", o_bus_valid, 0);
    tick();
    tick();
    check("lh_wait_done", o_done, 0);
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h8001_1234;
    tick();
    i_bus_rvalid = 1'b0;
    check("lh_done",  o_done, 1);
    check("lh_rdata", o_rdata, 32'hFFFF_8001);
    check("lh_idle",  o_busy, 0);

    // Stray rvalid in IDLE must not touch o_rdata
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h5555_5555;
    tick();
    i_bus_rvalid = 1'b0;
    check("stray_rdata", o_rdata, 32'hFFFF_8001);
    check("stray_done",  o_done, 0);

    // LHU 0x202, immediate response
    issue(1'b0, 3'b101, 32'h0000_0202, '0);
    tick();
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h8001_1234;
    tick();
    i_bus_rvalid = 1'b0;
    check("lhu_done",  o_done, 1);
    check("lhu_rdata", o_rdata, 32'h0000_8001);

    // LB 0x001 (sign) and LBU 0x003 (zero)
    issue(1'b0, 3'b000, 32'h0000_0001, '0);
    tick();
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h0000_F000;
    tick();
    i_bus_rvalid = 1'b0;
    check("lb_rdata", o_rdata, 32'hFFFF_FFF0);
    issue(1'b0, 3'b100, 32'h0000_0003, '0);
    tick();
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h9A00_0000;
    tick();
    i_bus_rvalid = 1'b0;
    check("lbu_rdata", o_rdata, 32'h0000_009A);

    // SH 0x012
    issue(1'b1, 3'b001, 32'h0000_0012, 32'h1234_BEEF);
    check("sh_be",    o_bus_be, 4'b1100);
    check("sh_wdata", o_bus_wdata, 32'hBEEF_BEEF);
    check("sh_addr",  o_bus_addr, 32'h0000_0010);
    tick();
    check("sh_done",  o_done, 1);

    // LW 0x006: misaligned
    issue(1'b0, 3'b010, 32'h0000_0006, '0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("lw_mis_err",   o_err, 1);
    check("lw_mis_valid", o_bus_valid, 0);
    check("lw_mis_busy",  o_busy, 0);
    tick();
    check("lw_mis_pulse", o_err, 0);
    check("lw_mis_valid2", o_bus_valid, 0);
`else
    check("lw_mis_err",   o_err, 0);
    check("lw_mis_valid", o_bus_valid, 1);
    check("lw_mis_addr",  o_bus_addr, 32'h0000_0004);
    check("lw_mis_be",    o_bus_be, 4'b1111);
    tick();
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h1122_3344;
    tick();
    i_bus_rvalid = 1'b0;
    check("lw_mis_done",  o_done, 1);
    check("lw_mis_rdata", o_rdata, 32'h1122_3344);
`endif

    // SW with ready held low 5 cycles; core keeps i_req high with other inputs
    i_bus_ready = 1'b0;
    issue(1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF);
    i_req   = 1'b1;
    i_addr  = 32'h0000_0888;
    i_wdata = 32'h0BAD_F00D;
    for (int unsigned k = 0; k < 5; k++) begin
      check("sw_hold_valid", o_bus_valid, 1);
      check("sw_hold_addr",  o_bus_addr, 32'h0000_0040);
      check("sw_hold_be",    o_bus_be, 4'b1111);
      check("sw_hold_wdata", o_bus_wdata, 32'hDEAD_BEEF);
      check("sw_hold_done",  o_done, 0);
      tick();
    end
    i_req       = 1'b0;
    i_bus_ready = 1'b1;
    tick();
    check("sw_done",  o_done, 1);
    check("sw_valid", o_bus_valid, 0);

    // Reset while waiting in RESP, then a late response
    issue(1'b0, 3'b010, 32'h0000_0080, '0);
    tick();
    check("rr_busy_pre", o_busy, 1);
    i_rst_n = 1'b0;
    #1;
    check("rr_busy",  o_busy, 0);
    check("rr_rdata", o_rdata, 0);
    check("rr_valid", o_bus_valid, 0);
    check("rr_addr",  o_bus_addr, 0);
    tick();
    i_rst_n      = 1'b1;
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'hCAFE_F00D;
    tick();
    i_bus_rvalid = 1'b0;
    check("rr_late_done",  o_done, 0);
    check("rr_late_rdata", o_rdata, 0);
    check("rr_late_busy",  o_busy, 0);

    // Illegal formats
    issue(1'b0, 3'b011, 32'h0000_0000, '0);
    check("ill_ld_err",   o_err, 1);
    check("ill_ld_valid", o_bus_valid, 0);
    tick();
    check("ill_ld_pulse", o_err, 0);
    issue(1'b1, 3'b100, 32'h0000_0000, 32'h1);
    check("ill_st_err",   o_err, 1);
    check("ill_st_valid", o_bus_valid, 0);
    check("ill_st_busy",  o_busy, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
